// File: rtl/sccb_arb_pkg.sv
// ============================================================================
// Module   : sccb_arb_pkg
// Brief    : Shared types and widths for the SCCB write-channel arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sccb_arb_pkg;

    localparam int unsigned SCCB_ADDR_W       = 16;
    localparam int unsigned SCCB_DATA_W       = 8;
    localparam int unsigned DEF_TIMEOUT_TICKS = 742_500;

    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        WRITE_S  = 2'd1,
        LOCKED_S = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sccb_wr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector: first valid index at or after
//            ptr_i, wrapping modulo NUM_REQ, as one-hot grant and index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    int unsigned      cand;
    logic [PTR_W-1:0] sel;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        sel   = '0;
        // Explicit wrap keeps this correct for non-power-of-two NUM_REQ.
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = int'(unsigned'(ptr_i)) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            sel = PTR_W'(cand);
            if (!any_o && valid_i[sel]) begin
                any_o      = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sccb_wr_arbiter.sv
// ============================================================================
// Module   : sccb_wr_arbiter
// Brief    : Round-robin arbiter with per-write lock sharing one SCCB write
//            channel. Optional write/lock-gap watchdog: ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_wr_arbiter
    import sccb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*SCCB_ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*SCCB_DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]             req_lock_i,
    output logic [NUM_REQ-1:0]             req_ack_o,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           sccb_wr_stb_o,
    output logic [SCCB_ADDR_W-1:0]         sccb_addr_o,
    output logic [SCCB_DATA_W-1:0]         sccb_data_o,
    input  logic                           sccb_done_i,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SCCB_ADDR_W-1:0] addr_q, addr_d;
    logic [SCCB_DATA_W-1:0] data_q, data_d;
    logic                   lock_q, lock_d;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [PTR_W-1:0]       owner_next;
    logic                   abort;

    logic [SCCB_ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [SCCB_DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k] = req_addr_i[SCCB_ADDR_W*k +: SCCB_ADDR_W];
        assign data_arr[k] = req_data_i[SCCB_DATA_W*k +: SCCB_DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign owner_next = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);

    logic [CNT_W-1:0] tick_q;
    logic             timeout_q;
    logic             tick_hit;

    assign tick_hit = (state_q != IDLE_S) && (tick_q == CNT_W'(TIMEOUT_TICKS - 1));
    // A completion or the owner's next request in the same cycle wins over the abort.
    assign abort    = tick_hit &&
                      !((state_q == WRITE_S)  && sccb_done_i) &&
                      !((state_q == LOCKED_S) && req_valid_i[owner_q]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                tick_q <= '0;
            end else if (state_q != IDLE_S) begin
                tick_q <= tick_q + CNT_W'(1);
            end
            timeout_q <= timeout_q | abort;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_ticks;

    assign unused_ticks = ^TIMEOUT_TICKS;
    assign abort        = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        lock_d    = lock_q;
        req_ack_o = '0;
        unique case (state_q)
            IDLE_S: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    data_d  = data_arr[pick_idx];
                    lock_d  = req_lock_i[pick_idx];
                    state_d = WRITE_S;
                end
            end
            WRITE_S: begin
                if (sccb_done_i) begin
                    req_ack_o = grant_q;
                    if (lock_q) begin
                        state_d = LOCKED_S;
                    end else begin
                        state_d  = IDLE_S;
                        grant_d  = '0;
                        rr_ptr_d = owner_next;
                    end
                end else if (abort) begin
                    req_ack_o = grant_q;
                    state_d   = IDLE_S;
                    grant_d   = '0;
                    rr_ptr_d  = owner_next;
                end
            end
            LOCKED_S: begin
                if (req_valid_i[owner_q]) begin
                    addr_d  = addr_arr[owner_q];
                    data_d  = data_arr[owner_q];
                    lock_d  = req_lock_i[owner_q];
                    state_d = WRITE_S;
                end else if (abort) begin
                    req_ack_o = grant_q;
                    state_d   = IDLE_S;
                    grant_d   = '0;
                    rr_ptr_d  = owner_next;
                end
            end
            default: begin
                state_d = IDLE_S;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE_S;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            lock_q   <= lock_d;
        end
    end

    assign grant_o       = grant_q;
    assign sccb_wr_stb_o = (state_q == WRITE_S);
    assign sccb_addr_o   = addr_q;
    assign sccb_data_o   = data_q;
    assign busy_o        = (state_q != IDLE_S);

endmodule

`default_nettype wire

// File: tb/tb_sccb_wr_arbiter.sv
// ============================================================================
// Module   : tb_sccb_wr_arbiter
// Brief    : Scoreboard bench for sccb_wr_arbiter with a simple adapter model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sccb_wr_arbiter;
    import sccb_arb_pkg::*;

    localparam int unsigned N     = 3;
    localparam int unsigned TICKS = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_lock  = '0;
    logic [N*16-1:0]   req_addr  = '0;
    logic [N*8-1:0]    req_data  = '0;
    logic              sccb_done = 1'b0;
    logic [N-1:0]      req_ack_o;
    logic [N-1:0]      grant_o;
    logic              sccb_wr_stb_o;
    logic [15:0]       sccb_addr_o;
    logic [7:0]        sccb_data_o;
    logic              busy_o;
    logic              timeout_o;

    typedef struct {
        int          idx;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        lock;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sccb_wr_arbiter #(
        .NUM_REQ       (N),
        .TIMEOUT_TICKS (TICKS)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .req_lock_i    (req_lock),
        .req_ack_o     (req_ack_o),
        .grant_o       (grant_o),
        .sccb_wr_stb_o (sccb_wr_stb_o),
        .sccb_addr_o   (sccb_addr_o),
        .sccb_data_o   (sccb_data_o),
        .sccb_done_i   (sccb_done),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int k, input logic [15:0] a, input logic [7:0] d, input logic lk);
        req_addr[16*k +: 16] = a;
        req_data[8*k +: 8]   = d;
        req_lock[k]          = lk;
        req_valid[k]         = 1'b1;
    endtask

    task automatic expect_wr(input int k, input logic [15:0] a, input logic [7:0] d, input logic lk);
        exp_t e;
        e.idx  = k;
        e.addr = a;
        e.data = d;
        e.lock = lk;
        sb.push_back(e);
    endtask

    task automatic push_req(input int k, input logic [15:0] a, input logic [7:0] d, input logic lk);
        drive_req(k, a, d, lk);
        expect_wr(k, a, d, lk);
    endtask

    // Adapter model: waits for the strobe, checks the write against the
    // scoreboard, returns done after 'delay' cycles and releases the requester.
    task automatic serve(input int delay, input bit mutate, output int lat);
        exp_t e;
        int   n;
        lat = 0;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!sccb_wr_stb_o && n < 64);
        lat = n;
        check_eq("wr_stb", sccb_wr_stb_o, 1);
        check_eq("grant", grant_o, 1 << e.idx);
        check_eq("addr", sccb_addr_o, e.addr);
        check_eq("data", sccb_data_o, e.data);
        if (mutate) begin
            req_addr[16*e.idx +: 16] = ~e.addr;
            req_data[8*e.idx +: 8]   = ~e.data;
            req_valid[e.idx]         = 1'b0;
        end
        repeat (delay) begin
            @(negedge clk_i);
            check_eq("ack_early", req_ack_o, 0);
        end
        check_eq("stb_hold", sccb_wr_stb_o, 1);
        check_eq("addr_hold", sccb_addr_o, e.addr);
        check_eq("data_hold", sccb_data_o, e.data);
        sccb_done = 1'b1;
        #1;
        check_eq("ack", req_ack_o, 1 << e.idx);
        @(negedge clk_i);
        sccb_done        = 1'b0;
        req_valid[e.idx] = 1'b0;
        check_eq("stb_gap", sccb_wr_stb_o, 0);
        check_eq("grant_after", grant_o, e.lock ? (1 << e.idx) : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        bit got_ack;

        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_eq("rst_grant", grant_o, 0);
        check_eq("rst_ack", req_ack_o, 0);
        check_eq("rst_stb", sccb_wr_stb_o, 0);
        check_eq("rst_addr", sccb_addr_o, 0);
        check_eq("rst_data", sccb_data_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_timeout", timeout_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // All three at once from reset: order 0,1,2 then 0 again.
        push_req(0, 16'h3008, 8'h82, 1'b0);
        push_req(1, 16'h3103, 8'h11, 1'b0);
        push_req(2, 16'h0100, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) serve(3, 1'b0, lat);
        push_req(0, 16'h3008, 8'h02, 1'b0);
        serve(2, 1'b0, lat);

        // Single request with a long adapter latency.
        push_req(1, 16'h0202, 8'h0A, 1'b0);
        serve(20, 1'b0, lat);
        check_eq("wr_stb_latency", lat, 1);

        // Pointer now past requester 1: requester 2 beats requester 0.
        push_req(2, 16'h0340, 8'h55, 1'b0);
        push_req(0, 16'h0341, 8'hAA, 1'b0);
        serve(1, 1'b0, lat);
        serve(1, 1'b0, lat);

        // Grouped-hold burst from requester 2 while requester 0 waits.
        drive_req(0, 16'h3500, 8'h10, 1'b0);
        push_req(2, 16'h0104, 8'h01, 1'b1);
        serve(2, 1'b0, lat);
        repeat (3) begin
            @(negedge clk_i);
            check_eq("lock_hold_grant", grant_o, 3'b100);
            check_eq("lock_hold_stb", sccb_wr_stb_o, 0);
            check_eq("lock_hold_busy", busy_o, 1);
        end
        push_req(2, 16'h0205, 8'h40, 1'b1);
        serve(2, 1'b0, lat);
        check_eq("locked_latency", lat, 1);
        push_req(2, 16'h0104, 8'h00, 1'b0);
        serve(2, 1'b0, lat);
        expect_wr(0, 16'h3500, 8'h10, 1'b0);
        serve(2, 1'b0, lat);

        // Stray done while idle.
        @(negedge clk_i);
        sccb_done = 1'b1;
        #1;
        check_eq("idle_done_ack", req_ack_o, 0);
        @(negedge clk_i);
        sccb_done = 1'b0;
        check_eq("idle_done_busy", busy_o, 0);
        check_eq("idle_done_stb", sccb_wr_stb_o, 0);

        // Inputs change and valid drops mid-write.
        push_req(1, 16'h5A5A, 8'hC3, 1'b0);
        serve(4, 1'b1, lat);

        // Reset in WRITE_S, then re-arbitration from pointer 0.
        drive_req(1, 16'h1111, 8'h22, 1'b0);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!sccb_wr_stb_o && n < 8);
        check_eq("pre_rst_grant", grant_o, 3'b010);
        drive_req(2, 16'h2222, 8'h33, 1'b0);
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_grant", grant_o, 0);
        check_eq("mid_rst_stb", sccb_wr_stb_o, 0);
        check_eq("mid_rst_addr", sccb_addr_o, 0);
        check_eq("mid_rst_data", sccb_data_o, 0);
        check_eq("mid_rst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        expect_wr(1, 16'h1111, 8'h22, 1'b0);
        expect_wr(2, 16'h2222, 8'h33, 1'b0);
        serve(2, 1'b0, lat);
        serve(2, 1'b0, lat);

`ifdef ARB_TIMEOUT_EN
        // No done for requester 0: abort after TICKS strobe cycles.
        drive_req(0, 16'h0F0F, 8'h5A, 1'b0);
        drive_req(1, 16'h0E0E, 8'hA5, 1'b0);
        n       = 0;
        got_ack = 1'b0;
        for (int c = 0; c < 40 && !got_ack; c++) begin
            @(negedge clk_i);
            if (sccb_wr_stb_o) n++;
            if (req_ack_o != 0) got_ack = 1'b1;
        end
        check_eq("to_ack", req_ack_o, 3'b001);
        check_eq("to_cycles", n, TICKS);
        req_valid[0] = 1'b0;
        expect_wr(1, 16'h0E0E, 8'hA5, 1'b0);
        serve(2, 1'b0, lat);
        check_eq("to_sticky", timeout_o, 1);
`else
        got_ack = 1'b0;
        check_eq("timeout_tied", {timeout_o, got_ack}, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sccb_wr_arbiter.md
Name: sccb_wr_arbiter

Overview:
- Shares the single SCCB register-write channel (16-bit addr, 8-bit data, wr_stb/done_stb handshake into the AXI4-Lite adapter) between NUM_REQ requesters.
- Typical requesters: the power-up/init sequencer, the exposure/gain controller and the debug CSR bridge.
- Round-robin arbitration with a per-write lock, so a requester can complete a grouped-parameter-hold burst (0x0104=1 … 0x0104=0) without interleaving.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_TICKS, 742_500, clk_i cycles allowed per write/lock gap before abort (10 ms at 74.25 MHz); used only with ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester write request, held until its ack
- req_addr_i  in  NUM_REQ*16  register addresses, requester k at [16k+15:16k]
- req_data_i  in  NUM_REQ*8  write data, requester k at [8k+7:8k]
- req_lock_i  in  NUM_REQ  keep grant after this write (burst not finished)
- req_ack_o  out  NUM_REQ  one-cycle pulse: requester's write completed (or aborted)
- grant_o  out  NUM_REQ  one-hot current owner, 0 when idle
- sccb_wr_stb_o  out  1  level write request to adapter
- sccb_addr_o  out  16  latched address
- sccb_data_o  out  8  latched data
- sccb_done_i  in  1  one-cycle completion pulse from adapter
- busy_o  out  1  state != IDLE_S
- timeout_o  out  1  sticky abort flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset values: grant_o=0, req_ack_o=0, sccb_wr_stb_o=0, sccb_addr_o=0, sccb_data_o=0, busy_o=0, timeout_o=0, rr_ptr=0, state=IDLE_S.
- States: IDLE_S, WRITE_S, LOCKED_S.
- IDLE_S:
  - If any req_valid_i, pick the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register grant, and latch addr/data/lock for that requester. Go to WRITE_S.
  - sccb_wr_stb_o rises exactly 1 cycle after valid is first seen.
- WRITE_S:
  - sccb_wr_stb_o=1, addr/data stable from latch. Input changes are ignored.
  - On sccb_done_i: req_ack_o[owner] pulses in the same cycle; sccb_wr_stb_o=0 from the next cycle.
  - If latched lock=1, go to LOCKED_S.
  - Else go to IDLE_S, rr_ptr = owner+1 (wrap to 0 at NUM_REQ), grant cleared.
- LOCKED_S:
  - Grant held; other requesters are not considered.
  - When req_valid_i[owner]=1, latch its addr/data/lock and go to WRITE_S, with wr_stb 1 cycle later.
- Minimum one cycle with sccb_wr_stb_o=0 between consecutive writes (the adapter needs a new edge).
- sccb_done_i outside WRITE_S is ignored.
- req_valid_i deasserted during WRITE_S: the write still completes and the ack still pulses; the requester must tolerate it.
- Owner deasserts lock: only the write carrying lock=0 releases the grant.
- Simultaneous done and new valid from another requester: the ack happens first, and arbitration occurs in the following IDLE_S cycle (2-cycle turnaround).
- rr_ptr width $clog2(NUM_REQ), compare and increment with explicit wrap; no power-of-two assumption.
- Reset mid-write: all outputs return to reset values immediately; the adapter shares rst_i so no dangling transaction.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With ARB_TIMEOUT_EN: tick counter ($clog2(TIMEOUT_TICKS+1) bits) clears on every state entry and counts in WRITE_S and LOCKED_S. On reaching TIMEOUT_TICKS:
  - req_ack_o[owner] pulses, timeout_o sets (sticky until rst_i), grant drops.
  - State goes to IDLE_S and rr_ptr advances past the owner.
- Without ARB_TIMEOUT_EN: no counter, timeout_o tied 0, a missing done stalls the arbiter indefinitely.

Decomposition:
- Package sccb_arb_pkg holds:
  - state enum arb_state_t (IDLE_S, WRITE_S, LOCKED_S);
  - SCCB_ADDR_W=16, SCCB_DATA_W=8;
  - default DEF_TIMEOUT_TICKS.
- One sub-module, rr_pick: combinational round-robin selector (valid vector, rr_ptr → one-hot grant + index). Kept separate so it can be unit-tested across NUM_REQ values.

Test Plan:
- Single request: req1 valid, addr 0x0202, data 0x0A; done 20 cycles after wr_stb → wr_stb one cycle after valid, addr/data match, ack[1] pulses with done, rr_ptr=2.
- All three valid at once from reset, no locks → grant order 0,1,2 then 0 again, each write separated by ≥1 idle stb cycle.
- Lock burst: req2 writes 0x0104=1 (lock), 0x0205=0x40 (lock), 0x0104=0 (unlock) while req0 stays valid → req0 not granted until after the third ack.
- Done pulse while IDLE_S and request data change mid-WRITE_S → no spurious ack; the latched addr/data are unchanged on the bus.
- rst_i asserted in WRITE_S for 1 cycle → all outputs 0 immediately; a pending request is re-arbitrated from rr_ptr=0 after release.
- ARB_TIMEOUT_EN with TIMEOUT_TICKS=16, no done returned → ack pulses after 16 cycles in WRITE_S, timeout_o=1 and sticky, next requester granted.
